mux_arbiter_4: RTL and testbench

MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

---
 rtl/mux_arbiter_4.sv | 81 ++++++++
 tb/tb_mux_arbiter_4.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4: round-robin 4-way arbiter driving a registered-select 4:1 data mux.
// Optional burst limit forcing hand-off after BURST_MAX owned cycles: define ARB_BURST_LIMIT_EN.
module mux_arbiter_4 #(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in00,
    input  logic [WIDTH-1:0] in01,
    input  logic [WIDTH-1:0] in10,
    input  logic [WIDTH-1:0] in11,
    output logic [3:0]       grant,
    output logic [1:0]       selector,
    output logic [WIDTH-1:0] out,
    output logic             valid
);
    typedef enum logic {IDLE, OWNED} state_t;
    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d, mreq;
    logic [1:0] sel_q, sel_d, last_q, last_d, win;
    logic       keep, force_off;

    // First set bit of r scanning upward (mod 4) from s; lower offsets overwrite later.
    function automatic logic [1:0] rr(input logic [3:0] r, input logic [1:0] s);
        rr = s;
        for (int k = 3; k >= 0; k--)
            if (r[s + 2'(k)]) rr = s + 2'(k);
    endfunction

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [3:0] CNT_TOP = 4'(BURST_MAX - 1);
    logic [3:0] cnt_q, cnt_d;
    assign force_off = (state_q == OWNED) && (cnt_q >= CNT_TOP) && |mreq;
    assign cnt_d     = keep ? ((cnt_q >= CNT_TOP) ? cnt_q : cnt_q + 4'd1) : 4'd0;
    always_ff @(posedge clk)
        cnt_q <= rst ? 4'd0 : cnt_d;
`else
    assign force_off = 1'b0;
`endif

    // The owner is masked out so a burst-limit hand-off never re-selects it.
    assign mreq = (state_q == OWNED) ? (req & ~grant_q) : req;
    assign win  = rr(mreq, last_q + 2'd1);
    assign keep = (state_q == OWNED) && req[sel_q] && !force_off;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (!keep) begin
            state_d = |mreq ? OWNED : IDLE;
            grant_d = |mreq ? (4'b0001 << win) : 4'b0000;
            sel_d   = |mreq ? win : sel_q;
            last_d  = |mreq ? win : last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign grant    = grant_q;
    assign selector = sel_q;
    assign valid    = |grant_q;
    assign out      = (sel_q == 2'd0) ? in00 :
                      (sel_q == 2'd1) ? in01 :
                      (sel_q == 2'd2) ? in10 : in11;
endmodule

// File: tb/tb_mux_arbiter_4.sv
// tb_mux_arbiter_4: directed scenario tasks with hand-computed expectations for mux_arbiter_4.
module tb_mux_arbiter_4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] in00 = 32'd0, in01 = 32'd1, in10 = 32'd2, in11 = 32'd3;
    logic [3:0]  grant;
    logic [1:0]  selector;
    logic [31:0] out;
    logic        valid;
    int total = 0;
    int bad   = 0;

    mux_arbiter_4 #(.WIDTH(32), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in00(in00), .in01(in01), .in10(in10), .in11(in11),
        .grant(grant), .selector(selector), .out(out), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b0000;
        step(); step();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        total++; if (selector !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b exp=00", selector); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        req = 4'b0001;
        step();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL first_grant got=%b exp=0001", grant); end
        total++; if (selector !== 2'b00) begin bad++; $display("FAIL first_sel got=%b exp=00", selector); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", valid); end
        total++; if (out !== 32'd0) begin bad++; $display("FAIL first_out got=%0d exp=0", out); end
        step();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL first_hold got=%b exp=0001", grant); end
        req = 4'b0000;
        step();
        total++; if (grant !== 4'b0000 || valid !== 1'b0) begin bad++; $display("FAIL first_idle grant=%b valid=%b exp=0000/0", grant, valid); end
        step();
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL idle_stay got=%b exp=0000", grant); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp = 4'b0001 << (i % 4);
            step();
            total++; if (grant !== exp || valid !== 1'b1) begin bad++; $display("FAIL rot_grant i=%0d got=%b/%b exp=%b/1", i, grant, valid, exp); end
            total++; if (out !== 32'(i % 4)) begin bad++; $display("FAIL rot_out i=%0d got=%0d exp=%0d", i, out, i % 4); end
            req = 4'b1111;
            step();
            total++; if (grant !== exp) begin bad++; $display("FAIL rot_hold i=%0d got=%b exp=%b", i, grant, exp); end
            req = 4'b1111 & ~exp;
        end
    endtask

    task automatic test_release();
        req = 4'b0100;
        step();
        total++; if (grant !== 4'b0100 || selector !== 2'b10) begin bad++; $display("FAIL rel_own got=%b/%b exp=0100/10", grant, selector); end
        req = 4'b0000;
        step();
        total++; if (grant !== 4'b0000 || valid !== 1'b0) begin bad++; $display("FAIL rel_idle got=%b/%b exp=0000/0", grant, valid); end
        total++; if (selector !== 2'b10 || out !== 32'd2) begin bad++; $display("FAIL rel_sel got=%b/%0d exp=10/2", selector, out); end
        in10 = 32'd99;
        #1;
        total++; if (out !== 32'd99) begin bad++; $display("FAIL idle_mux got=%0d exp=99", out); end
        in10 = 32'd2;
    endtask

    task automatic test_skip_wrap();
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b1010;
        step();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL skip1 got=%b exp=0010", grant); end
        req = 4'b1000;
        step();
        total++; if (grant !== 4'b1000 || out !== 32'd3) begin bad++; $display("FAIL skip3 got=%b/%0d exp=1000/3", grant, out); end
        req = 4'b0011;
        step();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap0 got=%b exp=0001", grant); end
        req = 4'b0010;
        step();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL blip_release got=%b exp=0010", grant); end
        req = 4'b0011;
        step();
        total++; if (grant !== 4'b0010) begin bad++; $display("FAIL blip_hold got=%b exp=0010", grant); end
    endtask

    task automatic test_mid_reset();
        logic [3:0] pat [6] = '{4'b1111, 4'b0110, 4'b1001, 4'b0000, 4'b1100, 4'b0101};
        req = 4'b0000;
        step();
        req = 4'b0100;
        step();
        total++; if (grant !== 4'b0100) begin bad++; $display("FAIL mr_setup got=%b exp=0100", grant); end
        req = 4'b1111; rst = 1'b1;
        step();
        total++; if (grant !== 4'b0000 || valid !== 1'b0 || selector !== 2'b00) begin bad++; $display("FAIL mr_revoke got=%b/%b/%b exp=0000/0/00", grant, valid, selector); end
        rst = 1'b0;
        step();
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mr_first got=%b exp=0001", grant); end
        for (int i = 0; i < 6; i++) begin
            req = pat[i];
            step();
            total++; if (!$onehot0(grant) || valid !== (grant != 4'b0000) || (valid && grant !== (4'b0001 << selector))) begin bad++; $display("FAIL onehot i=%0d grant=%b sel=%b valid=%b", i, grant, selector, valid); end
        end
    endtask

`ifdef ARB_BURST_LIMIT_EN
    task automatic test_burst();
        rst = 1'b1; req = 4'b0000;
        step();
        rst = 1'b0; req = 4'b0011;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                step();
                total++; if (grant !== (r == 0 ? 4'b0001 : 4'b0010)) begin bad++; $display("FAIL burst r=%0d c=%0d got=%b", r, c, grant); end
            end
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if (grant !== 4'b0001) begin bad++; $display("FAIL burst_sat c=%0d got=%b exp=0001", c, grant); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_release();
        test_skip_wrap();
        test_mid_reset();
`ifdef ARB_BURST_LIMIT_EN
        test_burst();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
